lc3_mem_ctrl: RTL and testbench

Memory interface stage of the LC-3 datapath: holds MAR and MDR, runs the multi-cycle memory handshake, and generates the LC-3 ready signal R. It consumes values from the shared 16-bit processor bus via `ld_mar` and `ld_mdr`. Its `mdr_out` feeds the GateMDR tristate buffer that drives MDR back onto the bus. A wait-cycle counter flags memory that never acknowledges.

---
 rtl/lc3_pkg.sv | 13 +
 rtl/wait_counter.sv | 30 +++
 rtl/lc3_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 datapath word width and memory-stage state type
package lc3_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2,
      HOLD = 2'd3
   } mem_state_t;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - memory wait-cycle counter with terminal count at TIMEOUT-1
module wait_counter #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // count wait cycles; parks at the terminal value so it can never wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == LAST);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 MAR/MDR memory stage with handshake FSM and R signal
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter int WIDTH   = WORD_W,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             ld_mar,
   input  logic             ld_mdr,
   input  logic             mio_en,
   input  logic             r_w,
   output logic [WIDTH-1:0] mar_out,
   output logic [WIDTH-1:0] mdr_out,
   output logic             ready,
   output logic             busy,
   output logic             timeout_err,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_we,
   output logic             mem_req,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack
);

   mem_state_t       state, state_nxt;
   logic [WIDTH-1:0] mar, mdr;
   logic             we_q, terr_q;
   logic             cnt_clr, cnt_en, cnt_tc;
   logic             mar_load, mdr_bus_load, mdr_mem_load, mdr_clear, set_terr;

   wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc    (cnt_tc)
   );

   // state register; async reset drops mem_req immediately since it decodes WAIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and register-load strobes; bus loads only while the address is not in use
   always_comb begin
      state_nxt    = state;
      cnt_clr      = 1'b1;
      cnt_en       = 1'b0;
      mar_load     = 1'b0;
      mdr_bus_load = 1'b0;
      mdr_mem_load = 1'b0;
      mdr_clear    = 1'b0;
      set_terr     = 1'b0;
      case (state)
         IDLE: begin
            mar_load     = ld_mar;
            mdr_bus_load = ld_mdr && !mio_en;
            if (mio_en) state_nxt = WAIT;
         end
         WAIT: begin
            cnt_clr = 1'b0;
            if (mem_ack) begin
               state_nxt    = DONE;
               mdr_mem_load = !we_q;
            end else if (cnt_tc) begin
               state_nxt = DONE;
               set_terr  = 1'b1;
               mdr_clear = !we_q;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            state_nxt = mio_en ? HOLD : IDLE;
         end
         HOLD: begin
            mar_load     = ld_mar;
            mdr_bus_load = ld_mdr && !mio_en;
            if (!mio_en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // MAR/MDR, sticky timeout flag and write strobe; memory data outranks the bus
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mar    <= '0;
         mdr    <= '0;
         terr_q <= 1'b0;
         we_q   <= 1'b0;
      end else begin
         if (mar_load) mar <= bus_in;
         if (mdr_mem_load) begin
            mdr <= mem_rdata;
         end else if (mdr_clear) begin
            mdr <= '0;
         end else if (mdr_bus_load) begin
            mdr <= bus_in;
         end
         if (set_terr) terr_q <= 1'b1;
         if (state == IDLE) begin
            we_q <= mio_en && r_w;
         end else if (state_nxt != WAIT) begin
            we_q <= 1'b0;
         end
      end
   end

   assign mar_out     = mar;
   assign mdr_out     = mdr;
   assign mem_addr    = mar;
   assign mem_wdata   = mdr;
   assign mem_we      = we_q;
   assign mem_req     = (state == WAIT);
   assign busy        = (state == WAIT);
   assign ready       = (state == DONE);
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - self-checking bench for lc3_mem_ctrl against a transaction-level model
module tb_lc3_mem_ctrl;

   localparam int TO = 15;

   logic        clk;
   logic        reset;
   logic [15:0] bus_in;
   logic        ld_mar, ld_mdr, mio_en, r_w;
   logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata, mem_rdata;
   logic        ready, busy, timeout_err, mem_we, mem_req, mem_ack;

   int          checks = 0;
   int          failures = 0;

   logic [15:0] mar_m, mdr_m;
   logic        terr_m;

   lc3_mem_ctrl #(.WIDTH(16), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_in      (bus_in),
      .ld_mar      (ld_mar),
      .ld_mdr      (ld_mdr),
      .mio_en      (mio_en),
      .r_w         (r_w),
      .mar_out     (mar_out),
      .mdr_out     (mdr_out),
      .ready       (ready),
      .busy        (busy),
      .timeout_err (timeout_err),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_req     (mem_req),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic load_mar(input logic [15:0] v);
      ld_mar = 1'b1;
      bus_in = v;
      tick();
      ld_mar = 1'b0;
      mar_m  = v;
      chk16("mar_load", mar_out, mar_m);
   endtask

   task automatic load_mdr(input logic [15:0] v);
      ld_mdr = 1'b1;
      mio_en = 1'b0;
      bus_in = v;
      tick();
      ld_mdr = 1'b0;
      mdr_m  = v;
      chk16("mdr_load", mdr_out, mdr_m);
   endtask

   // one memory transaction: ack_at is the WAIT cycle carrying the ack (0 or >TO: never)
   task automatic mem_op(input logic rw, input int ack_at, input logic [15:0] rdata, input bit hold);
      int   wc;
      int   exp_wc;
      logic done;
      logic acked;
      wc     = 0;
      done   = 1'b0;
      mio_en = 1'b1;
      r_w    = rw;
      for (int c = 0; c < 40 && !done; c++) begin
         tick();
         if (ready) begin
            done    = 1'b1;
            mem_ack = 1'b0;
            ld_mar  = 1'b0;
            ld_mdr  = 1'b0;
         end else if (mem_req) begin
            wc++;
            chk1("wait_mem_we", mem_we, rw);
            chk16("wait_mem_addr", mem_addr, mar_m);
            chk16("wait_mem_wdata", mem_wdata, mdr_m);
            mem_ack   = (wc == ack_at);
            mem_rdata = (wc == ack_at) ? rdata : 16'($urandom);
            ld_mar    = 1'($urandom_range(0, 1));
            ld_mdr    = mem_ack;
            bus_in    = 16'hFFFF;
         end else begin
            mem_ack = 1'b0;
         end
      end
      chk1("ready_seen", done, 1'b1);
      acked  = (ack_at >= 1 && ack_at <= TO);
      exp_wc = acked ? ack_at : TO;
      chk16("req_cycles", 16'(wc), 16'(exp_wc));
      if (!rw) mdr_m = acked ? rdata : 16'h0000;
      if (!acked) terr_m = 1'b1;
      chk16("done_mdr", mdr_out, mdr_m);
      chk16("done_mar", mar_out, mar_m);
      chk1("done_terr", timeout_err, terr_m);
      chk1("done_we", mem_we, 1'b0);
      chk1("done_busy", busy, 1'b0);
      if (hold) begin
         for (int h = 0; h < 3; h++) begin
            tick();
            chk1("hold_req", mem_req, 1'b0);
            chk1("hold_ready", ready, 1'b0);
         end
         mio_en = 1'b0;
         tick();
      end else begin
         mio_en = 1'b0;
         tick();
         chk1("ready_one_cycle", ready, 1'b0);
      end
      chk1("idle_req", mem_req, 1'b0);
      chk16("idle_mdr", mdr_out, mdr_m);
   endtask

   initial begin
      reset     = 1'b1;
      bus_in    = '0;
      ld_mar    = 1'b0;
      ld_mdr    = 1'b0;
      mio_en    = 1'b0;
      r_w       = 1'b0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      mar_m     = '0;
      mdr_m     = '0;
      terr_m    = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk16("rst_mar", mar_out, 16'h0000);
      chk16("rst_mdr", mdr_out, 16'h0000);
      chk1("rst_ready", ready, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_req", mem_req, 1'b0);
      chk1("rst_we", mem_we, 1'b0);
      chk1("rst_terr", timeout_err, 1'b0);

      // read with a 3-cycle memory, mio_en held afterwards
      load_mar(16'h3000);
      mem_op(1'b0, 3, 16'hBEEF, 1'b1);
      chk16("read_beef", mdr_out, 16'hBEEF);

      // write keeps MDR
      load_mar(16'h4010);
      load_mdr(16'h1234);
      mem_op(1'b1, 2, 16'h5555, 1'b0);
      chk16("write_mdr_kept", mdr_out, 16'h1234);

      // ack on the last allowed cycle wins over the timeout
      mem_op(1'b0, TO, 16'hA5A5, 1'b0);
      chk1("coincident_terr", timeout_err, 1'b0);

      // ack while idle is ignored
      mem_ack   = 1'b1;
      mem_rdata = 16'h0F0F;
      tick();
      mem_ack = 1'b0;
      chk1("stray_ack_busy", busy, 1'b0);
      chk1("stray_ack_ready", ready, 1'b0);
      chk16("stray_ack_mdr", mdr_out, mdr_m);

      // read timeout
      load_mar(16'($urandom));
      mem_op(1'b0, 0, 16'h0000, 1'b0);
      chk16("timeout_mdr", mdr_out, 16'h0000);
      chk1("timeout_sticky", timeout_err, 1'b1);

      // randomized transactions
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 1) load_mar(16'($urandom));
         if ($urandom_range(0, 1) == 1) load_mdr(16'($urandom));
         mem_op(1'($urandom_range(0, 1)), int'($urandom_range(0, TO + 3)),
                16'($urandom), 1'($urandom_range(0, 1)));
      end

      // reset in the middle of WAIT
      mio_en = 1'b1;
      r_w    = 1'b0;
      tick();
      chk1("pre_rst_req", mem_req, 1'b1);
      tick();
      reset = 1'b1;
      #1;
      chk1("async_rst_req", mem_req, 1'b0);
      chk1("async_rst_ready", ready, 1'b0);
      chk16("async_rst_mar", mar_out, 16'h0000);
      chk16("async_rst_mdr", mdr_out, 16'h0000);
      chk1("async_rst_terr", timeout_err, 1'b0);
      mio_en = 1'b0;
      mar_m  = '0;
      mdr_m  = '0;
      terr_m = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk1("post_rst_busy", busy, 1'b0);
      chk1("post_rst_req", mem_req, 1'b0);
      mem_op(1'b0, 1, 16'h7E57, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
